calc_stream_engine: RTL and testbench

- Parametrised successor of the fixed 64-bit calculator datapath.
- Combines the controller, ALU and result buffer into one sequencer with a start/busy/done handshake.
- Streams operand pairs from an external 1R/1W memory, applies a selectable operation, packs two results per memory word and writes them back.
- Sits between the SRAM macro wrapper and the top level; the SRAM macros stay outside this block.

---
 rtl/calculator_pkg.sv | 24 ++
 rtl/calc_alu.sv | 36 +++
 rtl/calc_stream_engine.sv | 173 +++++++++++++++++
 tb/tb_calc_stream_engine.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calculator_pkg.sv
// rtl/calculator_pkg.sv - shared types and defaults for the calculator stream engine
package calculator_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 9;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    READ,
    WAIT,
    CALC,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/calc_alu.sv
// rtl/calc_alu.sv - combinational add/sub/and/xor unit with carry/borrow flag
module calc_alu
  import calculator_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  op_e               op,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  logic [DATA_W:0] sum;

  // Select the operation; ovf is carry-out for add, borrow for sub, never for logic ops
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        ovf    = sum[DATA_W];
      end
      OP_SUB: begin
        result = a - b;
        ovf    = (a < b);
      end
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/calc_stream_engine.sv
// rtl/calc_stream_engine.sv - streams operand pairs from memory, computes, packs two results per word
module calc_stream_engine
  import calculator_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [1:0]          mode_i,
  input  logic [ADDR_W-1:0]   read_start_addr_i,
  input  logic [ADDR_W-1:0]   read_end_addr_i,
  input  logic [ADDR_W-1:0]   write_start_addr_i,
  input  logic [ADDR_W-1:0]   write_end_addr_i,
  output logic                rd_en_o,
  output logic [ADDR_W-1:0]   rd_addr_o,
  input  logic [2*DATA_W-1:0] rd_data_i,
  output logic                wr_en_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [2*DATA_W-1:0] wr_data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic                ovf_o,
  output logic [ADDR_W:0]     count_o
);

  localparam int MEM_W  = 2 * DATA_W;
  localparam int WCNT_W = $clog2(RD_LAT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(RD_LAT - 1);

  state_e              state;
  op_e                 op_q;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W-1:0]   rd_end;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   wr_end;
  logic [WCNT_W-1:0]   wait_cnt;
  logic [MEM_W-1:0]    opnd;
  logic [MEM_W-1:0]    buf_q;
  logic                sel;
  logic                more_reads;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_ovf;
  logic                last_read;

  assign last_read = (rd_ptr == rd_end);

  calc_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (opnd[DATA_W-1:0]),
    .b      (opnd[MEM_W-1:DATA_W]),
    .op     (op_q),
    .result (alu_res),
    .ovf    (alu_ovf)
  );

  // Sequencer: walks read/write pointers, packs results and drives all registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      op_q       <= OP_ADD;
      rd_ptr     <= '0;
      rd_end     <= '0;
      wr_ptr     <= '0;
      wr_end     <= '0;
      wait_cnt   <= '0;
      opnd       <= '0;
      buf_q      <= '0;
      sel        <= 1'b0;
      more_reads <= 1'b0;
      rd_en_o    <= 1'b0;
      rd_addr_o  <= '0;
      wr_en_o    <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      ovf_o      <= 1'b0;
      count_o    <= '0;
    end else begin
      // strobes are single-cycle unless a state below re-asserts them
      rd_en_o <= 1'b0;
      wr_en_o <= 1'b0;
      done_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state   <= CHECK;
            busy_o  <= 1'b1;
            err_o   <= 1'b0;
            ovf_o   <= 1'b0;
            count_o <= '0;
            op_q    <= op_e'(mode_i);
            rd_ptr  <= read_start_addr_i;
            rd_end  <= read_end_addr_i;
            wr_ptr  <= write_start_addr_i;
            wr_end  <= write_end_addr_i;
            buf_q   <= '0;
            sel     <= 1'b0;
          end
        end
        CHECK: begin
          // an inverted range on either side aborts before touching memory
          if ((rd_end < rd_ptr) || (wr_end < wr_ptr)) begin
            err_o  <= 1'b1;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            rd_en_o   <= 1'b1;
            rd_addr_o <= rd_ptr;
            state     <= READ;
          end
        end
        READ: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // capture the word in the exact cycle the memory presents it
          if (wait_cnt == WAIT_LAST) begin
            opnd  <= rd_data_i;
            state <= CALC;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        CALC: begin
          count_o    <= count_o + (ADDR_W + 1)'(1);
          ovf_o      <= ovf_o | alu_ovf;
          sel        <= ~sel;
          more_reads <= ~last_read;
          if (!last_read) rd_ptr <= rd_ptr + ADDR_W'(1);
          if (!sel) buf_q[DATA_W-1:0]     <= alu_res;
          else      buf_q[MEM_W-1:DATA_W] <= alu_res;
          if (!sel && !last_read) begin
            rd_en_o   <= 1'b1;
            rd_addr_o <= rd_ptr + ADDR_W'(1);
            state     <= READ;
          end else begin
            // odd tail leaves the high half zero
            wr_en_o   <= 1'b1;
            wr_addr_o <= wr_ptr;
            wr_data_o <= sel ? {alu_res, buf_q[DATA_W-1:0]} : {{DATA_W{1'b0}}, alu_res};
            state     <= WRITE;
          end
        end
        WRITE: begin
          buf_q <= '0;
          sel   <= 1'b0;
          if (more_reads && (wr_ptr != wr_end)) begin
            wr_ptr    <= wr_ptr + ADDR_W'(1);
            rd_en_o   <= 1'b1;
            rd_addr_o <= rd_ptr;
            state     <= READ;
          end else begin
            // reads left over with no room to write them is a truncation
            if (more_reads) err_o <= 1'b1;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_stream_engine.sv
// tb/tb_calc_stream_engine.sv - self-checking bench for calc_stream_engine
module tb_calc_stream_engine;

  localparam int DW  = 32;
  localparam int AW  = 9;
  localparam int LAT = 2;
  localparam int MW  = 2 * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] rsa, rea, wsa, wea;
  logic          rd_en, wr_en, busy, done, err, ovf;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [MW-1:0] rd_data, wr_data;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  calc_stream_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode),
    .read_start_addr_i(rsa), .read_end_addr_i(rea),
    .write_start_addr_i(wsa), .write_end_addr_i(wea),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .busy_o(busy), .done_o(done), .err_o(err), .ovf_o(ovf), .count_o(count)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [MW-1:0] data;
  } wr_t;

  logic [MW-1:0] mem  [0:511];
  logic [MW-1:0] pipe [0:LAT-1];
  wr_t           wlog [$];
  int            overlap = 0;
  int            rst_strobes = 0;

  assign rd_data = pipe[LAT-1];

  // memory with LAT-cycle read pipeline; writes are logged rather than stored
  always @(posedge clk) begin
    pipe[0] <= rd_en ? mem[rd_addr] : 64'hDEADBEEF_0BADF00D;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    if (wr_en) wlog.push_back('{addr: wr_addr, data: wr_data});
    if (rd_en && wr_en) overlap <= overlap + 1;
    if (!rst_n && (rd_en || wr_en)) rst_strobes <= rst_strobes + 1;
  end

  int total = 0;
  int bad = 0;
  int base = 0;
  int cur_ws = 0;

  logic [MW-1:0] exp_q [$];
  bit            exp_e, exp_o;
  int            exp_cnt, exp_lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // reference: result list from operand words, packed two per word, capped by write capacity
  task automatic model(input logic [1:0] m, input int rs, input int re, input int ws, input int we);
    logic [31:0] res [$];
    logic [32:0] s;
    logic [31:0] a, b, r;
    int n, cap, words;
    exp_q.delete();
    exp_e = 0; exp_o = 0; exp_cnt = 0;
    if (re < rs || we < ws) begin
      exp_e = 1; exp_lat = 2;
      return;
    end
    n   = re - rs + 1;
    cap = 2 * (we - ws + 1);
    exp_cnt = (n < cap) ? n : cap;
    exp_e   = (n > cap);
    for (int i = 0; i < exp_cnt; i++) begin
      a = mem[rs+i][31:0];
      b = mem[rs+i][63:32];
      case (m)
        2'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; if (s[32]) exp_o = 1; end
        2'd1: begin r = a - b; if (a < b) exp_o = 1; end
        2'd2: r = a & b;
        default: r = a ^ b;
      endcase
      res.push_back(r);
    end
    words = (exp_cnt + 1) / 2;
    for (int j = 0; j < words; j++)
      exp_q.push_back({(2*j+1 < exp_cnt) ? res[2*j+1] : 32'h0, res[2*j]});
    exp_lat = 2 + exp_cnt * (LAT + 2) + words;
  endtask

  task automatic kick(input logic [1:0] m, input int rs, input int re, input int ws, input int we);
    mode = m; rsa = AW'(rs); rea = AW'(re); wsa = AW'(ws); wea = AW'(we);
    cur_ws = ws;
    base = wlog.size();
    start = 1'b1;
  endtask

  task automatic wait_done(input bit poke, output int lat);
    int cyc;
    bit seen;
    cyc = 0; seen = 0; lat = -1;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        chk("accept_state", {busy, err, ovf, done}, 4'b1000);
        chk("count_cleared", count, 0);
      end
      if (poke && cyc == 3) start = 1'b1;
      if (poke && cyc == 4) start = 1'b0;
      if (done) begin seen = 1; lat = cyc; end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done want pulse within 3000 cycles");
    end
  endtask

  task automatic run_cfg(input logic [1:0] m, input int rs, input int re, input int ws, input int we,
                         output int lat);
    @(negedge clk);
    kick(m, rs, re, ws, we);
    wait_done(1'b0, lat);
  endtask

  task automatic check_model(input int lat);
    int nw;
    chk("latency", lat, exp_lat);
    chk("err", err, exp_e);
    chk("ovf", ovf, exp_o);
    chk("count", count, exp_cnt);
    chk("busy_at_done", busy, 0);
    nw = wlog.size() - base;
    chk("n_writes", nw, exp_q.size());
    for (int j = 0; j < nw && j < exp_q.size(); j++) begin
      chk("wr_addr", wlog[base+j].addr, cur_ws + j);
      chk("wr_data", wlog[base+j].data, exp_q[j]);
    end
  endtask

  typedef struct {
    logic [1:0]  mode;
    int          rs, re, ws, we;
    logic [31:0] a0, b0, a1, b1;
    bit          e, o;
    int          cnt, nwr, lat;
    logic [63:0] w0;
  } vec_t;

  vec_t tv [9];

  initial begin
    int lat, nw, rs, re, ws, we;
    logic [1:0] m;

    tv[0] = '{2'd0, 0, 1, 8, 8, 32'd3, 32'd2, 32'd5, 32'd10, 1'b0, 1'b0, 2, 1, 11, {32'd15, 32'd5}};
    tv[1] = '{2'd1, 0, 0, 4, 7, 32'd3, 32'd5, 32'd0, 32'd0, 1'b0, 1'b1, 1, 1, 7, {32'h0, 32'hFFFFFFFE}};
    tv[2] = '{2'd0, 0, 0, 20, 20, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 1, 1, 7, 64'h0};
    tv[3] = '{2'd0, 5, 2, 0, 3, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 0, 0, 2, 64'h0};
    tv[4] = '{2'd2, 0, 5, 10, 11, 32'hF0F0F0F0, 32'hFF00FF00, 32'h12345678, 32'h0000FFFF,
              1'b1, 1'b0, 4, 2, 20, {32'h00005678, 32'hF000F000}};
    tv[5] = '{2'd3, 0, 1, 9, 3, 32'd1, 32'd2, 32'd3, 32'd4, 1'b1, 1'b0, 0, 0, 2, 64'h0};
    tv[6] = '{2'd3, 3, 4, 30, 30, 32'hAAAA5555, 32'hFFFF0000, 32'd1, 32'd3,
              1'b0, 1'b0, 2, 1, 11, {32'd2, 32'h55555555}};
    tv[7] = '{2'd1, 0, 0, 40, 40, 32'd10, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 1, 1, 7, {32'd0, 32'd6}};
    tv[8] = '{2'd0, 510, 511, 511, 511, 32'd7, 32'd8, 32'd1, 32'd1, 1'b0, 1'b0, 2, 1, 11, {32'd2, 32'd15}};

    for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom};
    rst_n = 1'b0; start = 1'b0; mode = '0; rsa = '0; rea = '0; wsa = '0; wea = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {rd_en, rd_addr, wr_en, wr_addr, busy, done, err, ovf, count}, 0);
    chk("reset_wdata", wr_data, 0);
    rst_n = 1'b1;

    // directed table
    for (int t = 0; t < 9; t++) begin
      for (int i = tv[t].rs; i <= tv[t].re; i++) mem[i] = {$urandom, $urandom};
      mem[tv[t].rs] = {tv[t].b0, tv[t].a0};
      if (tv[t].rs + 1 <= 511) mem[tv[t].rs+1] = {tv[t].b1, tv[t].a1};
      run_cfg(tv[t].mode, tv[t].rs, tv[t].re, tv[t].ws, tv[t].we, lat);
      chk("tv_latency", lat, tv[t].lat);
      chk("tv_err", err, tv[t].e);
      chk("tv_ovf", ovf, tv[t].o);
      chk("tv_count", count, tv[t].cnt);
      chk("tv_busy_at_done", busy, 0);
      nw = wlog.size() - base;
      chk("tv_n_writes", nw, tv[t].nwr);
      if (nw > 0) begin
        chk("tv_first_addr", wlog[base].addr, tv[t].ws);
        chk("tv_last_addr", wlog[base+nw-1].addr, tv[t].ws + tv[t].nwr - 1);
        chk("tv_first_word", wlog[base].data, tv[t].w0);
      end
      @(negedge clk);
      chk("tv_done_pulse", done, 0);
    end

    // start during DONE is ignored, accepted the next cycle; start while busy is ignored
    for (int i = 0; i < 4; i++) mem[i] = {$urandom, $urandom};
    model(2'd0, 0, 1, 300, 300);
    run_cfg(2'd0, 0, 1, 300, 300, lat);
    check_model(lat);
    model(2'd1, 2, 3, 310, 311);
    kick(2'd1, 2, 3, 310, 311);
    @(negedge clk);
    chk("start_in_done_ignored", busy, 0);
    wait_done(1'b1, lat);
    check_model(lat);

    // reset asserted while waiting on read data
    @(negedge clk);
    kick(2'd0, 0, 1, 320, 320);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_abort", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {rd_en, rd_addr, wr_en, wr_addr, busy, done, err, ovf, count}, 0);
    chk("abort_wdata", wr_data, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_writes", wlog.size() - base, 0);
    chk("abort_no_strobes", rst_strobes, 0);
    rst_n = 1'b1;
    model(2'd0, 0, 1, 320, 320);
    run_cfg(2'd0, 0, 1, 320, 320, lat);
    check_model(lat);

    // randomized runs against the reference model
    for (int it = 0; it < 20; it++) begin
      m  = 2'($urandom_range(0, 3));
      rs = $urandom_range(0, 250);
      re = rs + $urandom_range(0, 8);
      ws = 256 + $urandom_range(0, 200);
      we = ws + $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0 && rs > 0) re = rs - 1;
      if ($urandom_range(0, 7) == 0) we = ws - 1;
      for (int i = rs; i <= re; i++) mem[i] = {$urandom, $urandom};
      model(m, rs, re, ws, we);
      run_cfg(m, rs, re, ws, we, lat);
      check_model(lat);
    end

    chk("rd_wr_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
